// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the comparator-sharing arbiter.
// Holds the FSM state encoding, default sizes and the round-robin picker.
package cmp_share_pkg;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_e;

    localparam int N_DEF       = 8;
    localparam int NUM_REQ_DEF = 4;
    localparam int RR_MAX      = 16;

    // Unused upper request bits are zero, so a 16-wide circular search
    // wraps from NUM_REQ-1 back to 0 for any NUM_REQ up to 16.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                  input logic [3:0]        ptr);
        logic [RR_MAX-1:0] gnt;
        logic              found;
        logic [3:0]        idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            idx = ptr + 4'(i);
            if (!found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_cmp_core.sv
// Combinational N-bit magnitude comparator shared by all requesters.
// Build with CMP_SIGNED_EN defined for two's-complement comparison; unsigned otherwise.
module cmp_core #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);

`ifdef CMP_SIGNED_EN
    logic signed [N-1:0] a_s;
    logic signed [N-1:0] b_s;
    assign a_s  = a_i;
    assign b_s  = b_i;
    assign gt_o = (a_s > b_s);
    assign lt_o = (a_s < b_s);
`else
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
`endif
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one comparator between NUM_REQ requesters (IDLE -> CMP -> RESP).
// Signedness follows the CMP_SIGNED_EN macro, applied inside cmp_core.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter  int N       = N_DEF,
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_gt,
    output logic                 rsp_lt,
    output logic                 rsp_eq,
    input  logic                 rsp_ready
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic               core_gt, core_lt, core_eq;

    assign pick = NUM_REQ'(rr_pick(RR_MAX'(req_valid), 4'(rr_ptr_q)));

    always_comb begin
        grant = '0;
        if (rst_n && state_q == IDLE) begin
            grant = pick;
        end
    end

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

    cmp_core #(.N(N)) u_core (
        .a_i  (a_q),
        .b_i  (b_q),
        .gt_o (core_gt),
        .lt_o (core_lt),
        .eq_o (core_eq)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d      = req_a[gnt_id*N +: N];
                    b_d      = req_b[gnt_id*N +: N];
                    id_d     = gnt_id;
                    rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    state_d  = CMP;
                end
            end
            CMP: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                gt_d        = core_gt;
                lt_d        = core_lt;
                eq_d        = core_eq;
                state_d     = RESP;
            end
            RESP: begin
                // Flags and ID are cleared with valid so idle outputs read as zero.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = '0;
                    gt_d        = 1'b0;
                    lt_d        = 1'b0;
                    eq_d        = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = gt_q;
    assign rsp_lt    = lt_q;
    assign rsp_eq    = eq_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: expected responses are queued at grant time
// and compared as responses appear; directed cases cover the listed scenarios.
module tb_cmp_share_arbiter;

    localparam int N       = 8;
    localparam int NUM_REQ = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic                 rsp_gt, rsp_lt, rsp_eq;
    logic                 rsp_ready;

    int checks = 0;
    int errors = 0;

    logic [4:0] sbq[$];
    int         m_ph  = 0;
    int         m_ptr = 0;

    cmp_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_pick(input logic [3:0] v, input int ptr);
        logic [3:0] g;
        g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g == 0 && v[(ptr + i) % NUM_REQ]) g[(ptr + i) % NUM_REQ] = 1'b1;
        end
        return g;
    endfunction

    // Returns {gt, lt, eq}
    function automatic logic [2:0] model_cmp(input logic [7:0] a, input logic [7:0] b);
        int ai, bi;
`ifdef CMP_SIGNED_EN
        ai = int'($signed(a));
        bi = int'($signed(b));
`else
        ai = int'(a);
        bi = int'(b);
`endif
        return {ai > bi, ai < bi, ai == bi};
    endfunction

    // Reference model + scoreboard, evaluated mid-cycle for the upcoming edge.
    initial begin
        logic [3:0] er;
        logic [4:0] e;
        int         g;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ph  = 0;
                m_ptr = 0;
                sbq.delete();
            end else begin
                er = (m_ph == 0) ? model_pick(req_valid, m_ptr) : 4'b0;
                chk("req_ready", 32'(req_ready), 32'(er));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = sbq[0];
                        chk("rsp_id", 32'(rsp_id), 32'(e[4:3]));
                        chk("rsp_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(e[2:0]));
                        chk("onehot", 32'(rsp_gt) + 32'(rsp_lt) + 32'(rsp_eq), 32'd1);
                    end
                end else begin
                    chk("idle_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'd0);
                end
                if (m_ph == 0 && er != 0) begin
                    g = 0;
                    for (int i = 0; i < NUM_REQ; i++) if (er[i]) g = i;
                    sbq.push_back({2'(g), model_cmp(req_a[g*N +: N], req_b[g*N +: N])});
                    m_ptr = (g + 1) % NUM_REQ;
                    m_ph  = 1;
                end else if (m_ph == 1) begin
                    m_ph = 2;
                end else if (m_ph == 2 && rsp_ready) begin
                    if (sbq.size() > 0) void'(sbq.pop_front());
                    m_ph = 0;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic wait_grant(output int idx);
        logic [3:0] acc;
        idx = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != 0) begin
                for (int i = 0; i < NUM_REQ; i++) if (acc[i]) idx = i;
                break;
            end
        end
        if (idx < 0) chk("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle(input bit rand_ready);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (m_ph == 0 && sbq.size() == 0) begin
                done = 1'b1;
                break;
            end
            rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rsp_ready = 1'b1;
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_flags"}, 32'({rsp_gt, rsp_lt, rsp_eq}), 32'd0);
    endtask

    initial begin
        int g;
        int order[5];
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four held with equal operands: grants 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'h0C, 8'h0C);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            order[k] = g;
        end
        @(posedge clk);
        #1 req_valid = '0;
        for (int k = 0; k < 5; k++) chk("all_order", 32'(order[k]), 32'(k % NUM_REQ));
        wait_idle(1'b0);

        // Single request on port 2.
        set_op(2, 8'h0A, 8'h0B);
        req_valid = 4'b0100;
        wait_grant(g);
        chk("single_grant", 32'(g), 32'd2);
        chk("single_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'b010);
        wait_idle(1'b0);

        // Pointer now 3: requesters 0 and 3 -> 3 first, then 0.
        set_op(0, 8'h01, 8'h02);
        set_op(3, 8'h05, 8'h04);
        req_valid = 4'b1001;
        wait_grant(g);
        chk("wrap_first", 32'(g), 32'd3);
        wait_grant(g);
        chk("wrap_second", 32'(g), 32'd0);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle(1'b0);

        // Backpressure: hold RESP for five cycles.
        set_op(1, 8'h0F, 8'h09);
        req_valid = 4'b0010;
        wait_grant(g);
        @(posedge clk);
        #1 begin
            req_valid = '0;
            rsp_ready = 1'b0;
        end
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_gt", 32'(rsp_gt), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            req_valid = 4'b1111;
            chk("bp_ready", 32'(req_ready), 32'd0);
            req_valid = '0;
            @(posedge clk);
        end
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_done", 32'(rsp_valid), 32'd0);
        wait_idle(1'b0);

        // Reset in CMP aborts; first grant afterwards is the lowest valid index.
        set_op(3, 8'h33, 8'h22);
        req_valid = 4'b1000;
        wait_grant(g);
        @(posedge clk);
        #1 req_valid = '0;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("abort");
        req_valid = 4'b1010;
        set_op(1, 8'h44, 8'h44);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_grant(g);
        chk("post_reset_grant", 32'(g), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle(1'b0);

        // Signedness boundary.
        set_op(0, 8'h80, 8'h7F);
        req_valid = 4'b0001;
        wait_grant(g);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
`ifdef CMP_SIGNED_EN
        chk("sign_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'b010);
`else
        chk("sign_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'b100);
`endif
        wait_idle(1'b0);

        // Random masks, operands (including extremes) and response backpressure.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(0, 3))
                    0: set_op(i, 8'h00, 8'($urandom_range(0, 255)));
                    1: set_op(i, 8'hFF, 8'($urandom_range(0, 255)));
                    2: set_op(i, 8'(i * 17), 8'(i * 17));
                    default: set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                endcase
            end
            req_valid = 4'($urandom_range(1, 15));
            wait_grant(g);
            @(posedge clk);
            #1 req_valid = '0;
            wait_idle(1'b1);
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
